// File: rtl/tiny_cpu_core_p.sv
// Parametrised 4-register accumulator CPU with loadable instruction memory,
// LOAD/RUN/HALT control, memory-mapped I/O at address 15 and a retired counter.
module tiny_cpu_core_p #(
   parameter int DATA_W     = 8,
   parameter int IMEM_DEPTH = 16,
   parameter int CNT_W      = 16,
   localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [7:0]        prog_data,
   input  logic              run,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_valid,
   output logic              busy,
   output logic              halted,
   output logic [PC_W-1:0]   pc,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;
   typedef enum logic [1:0] {OP_LD, OP_ST, OP_ALU, OP_JZ} opcode_t;

   localparam logic [3:0] IO_ADDR = 4'hF;

   state_t            state;
   logic [7:0]        imem [IMEM_DEPTH];
   logic [DATA_W-1:0] regs [4];
   logic [DATA_W-1:0] dmem [15];

   logic [7:0]        instr;
   opcode_t           opcode;
   logic [1:0]        ra, rb, func;
   logic [3:0]        imm;
   logic [DATA_W-1:0] a_val, b_val, alu_res, ld_val;
   logic [PC_W-1:0]   pc_inc, jz_target;

   // NOTE: program storage has no reset; its contents must survive a core reset,
   // and leaving it out of the reset net lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (prog_we && state != S_RUN)
         imem[prog_addr] <= prog_data;
   end

   assign instr     = imem[pc];
   assign opcode    = opcode_t'(instr[7:6]);
   assign ra        = instr[5:4];
   assign rb        = instr[3:2];
   assign func      = instr[1:0];
   assign imm       = instr[3:0];
   assign a_val     = regs[ra];
   assign b_val     = regs[rb];
   assign pc_inc    = pc + PC_W'(1);
   assign jz_target = PC_W'(imm);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      alu_res = '0;
      unique case (func)
         2'b00: alu_res = a_val + b_val;
         2'b01: alu_res = a_val - b_val;
         2'b10: alu_res = a_val & b_val;
         2'b11: alu_res = a_val ^ b_val;
      endcase
   end

   always_comb begin
      ld_val = in_port;
      if (imm != IO_ADDR)
         ld_val = dmem[imm];
   end

   // NOTE: all state here uses non-blocking assignments so every update lands
   // on the same edge and reads see the pre-edge values (ALU rA==rB is safe).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_LOAD;
         pc        <= '0;
         out_port  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         retired   <= '0;
         for (int i = 0; i < 4; i++)  regs[i] <= '0;
         for (int i = 0; i < 15; i++) dmem[i] <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_LOAD, S_HALT: begin
               if (run) begin
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  halted  <= 1'b0;
                  pc      <= '0;
                  retired <= '0;
               end
            end
            S_RUN: begin
               if (retired != '1)
                  retired <= retired + CNT_W'(1);
               pc <= pc_inc;
               case (opcode)
                  OP_LD:  regs[ra] <= ld_val;
                  OP_ST: begin
                     if (imm == IO_ADDR) begin
                        out_port  <= a_val;
                        out_valid <= 1'b1;
                     end else begin
                        dmem[imm] <= a_val;
                     end
                  end
                  OP_ALU: regs[ra] <= alu_res;
                  OP_JZ: begin
                     if (a_val == '0) begin
                        pc <= jz_target;
                        // A taken jump onto itself is the halt idiom.
                        if (jz_target == pc) begin
                           state  <= S_HALT;
                           busy   <= 1'b0;
                           halted <= 1'b1;
                        end
                     end
                  end
               endcase
            end
            default: begin
               state  <= S_LOAD;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tiny_cpu_core_p.sv
// Directed bench: instance A (8-bit, 16 words) and instance B (12-bit, 32 words,
// 4-bit counter) run hand-assembled programs with hand-computed results.
module tb_tiny_cpu_core_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: DATA_W=8, IMEM_DEPTH=16, CNT_W=16
   logic        a_reset = 1'b1, a_prog_we = 1'b0, a_run = 1'b0;
   logic [3:0]  a_prog_addr = '0;
   logic [7:0]  a_prog_data = '0, a_in_port = '0, a_out_port;
   logic        a_out_valid, a_busy, a_halted;
   logic [3:0]  a_pc;
   logic [15:0] a_retired;

   // Instance B: DATA_W=12, IMEM_DEPTH=32, CNT_W=4
   logic        b_reset = 1'b1, b_prog_we = 1'b0, b_run = 1'b0;
   logic [4:0]  b_prog_addr = '0;
   logic [7:0]  b_prog_data = '0;
   logic [11:0] b_in_port = '0, b_out_port;
   logic        b_out_valid, b_busy, b_halted;
   logic [4:0]  b_pc;
   logic [3:0]  b_retired;

   tiny_cpu_core_p dut_a (
      .clk(clk), .reset(a_reset), .prog_we(a_prog_we), .prog_addr(a_prog_addr),
      .prog_data(a_prog_data), .run(a_run), .in_port(a_in_port),
      .out_port(a_out_port), .out_valid(a_out_valid), .busy(a_busy),
      .halted(a_halted), .pc(a_pc), .retired(a_retired)
   );

   tiny_cpu_core_p #(.DATA_W(12), .IMEM_DEPTH(32), .CNT_W(4)) dut_b (
      .clk(clk), .reset(b_reset), .prog_we(b_prog_we), .prog_addr(b_prog_addr),
      .prog_data(b_prog_data), .run(b_run), .in_port(b_in_port),
      .out_port(b_out_port), .out_valid(b_out_valid), .busy(b_busy),
      .halted(b_halted), .pc(b_pc), .retired(b_retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [3:0] addr, input logic [7:0] data);
      a_prog_we = 1'b1; a_prog_addr = addr; a_prog_data = data;
      tick();
      a_prog_we = 1'b0;
   endtask

   task automatic load_b(input logic [4:0] addr, input logic [7:0] data);
      b_prog_we = 1'b1; b_prog_addr = addr; b_prog_data = data;
      tick();
      b_prog_we = 1'b0;
   endtask

   task automatic run_a();
      a_run = 1'b1; tick(); a_run = 1'b0;
   endtask

   task automatic run_b();
      b_run = 1'b1; tick(); b_run = 1'b0;
   endtask

   initial begin
      tick(); tick();
      check("rst_out_port", a_out_port, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_halted", a_halted, 0);
      check("rst_pc", a_pc, 0);
      check("rst_retired", a_retired, 0);
      a_reset = 1'b0; b_reset = 1'b0;
      tick();

      // Test 1: LD R0,[0]; JZ R1,1. Word 0 is written in the same cycle as run.
      load_a(4'd1, 8'hD1);
      a_prog_we = 1'b1; a_prog_addr = 4'd0; a_prog_data = 8'h00; a_run = 1'b1;
      tick();
      a_prog_we = 1'b0; a_run = 1'b0;
      check("t1_busy_start", a_busy, 1);
      check("t1_pc_start", a_pc, 0);
      tick();
      check("t1_pc_after_ld", a_pc, 1);
      check("t1_halted_after_ld", a_halted, 0);
      tick();
      check("t1_halted", a_halted, 1);
      check("t1_busy", a_busy, 0);
      check("t1_pc", a_pc, 1);
      check("t1_retired", a_retired, 2);

      // Test 2: F0 + 20 wraps to 10 on the output port (loaded while halted).
      load_a(4'd0, 8'h0F);  // LD R0,[15]
      load_a(4'd1, 8'h1F);  // LD R1,[15]
      load_a(4'd2, 8'h84);  // ADD R0,R1
      load_a(4'd3, 8'h4F);  // ST R0,[15]
      load_a(4'd4, 8'hE4);  // JZ R2,4
      run_a();
      check("t2_retired_cleared", a_retired, 0);
      a_in_port = 8'hF0; tick();
      a_in_port = 8'h20; tick();
      tick();
      check("t2_valid_before_st", a_out_valid, 0);
      tick();
      check("t2_out_port", a_out_port, 8'h10);
      check("t2_out_valid", a_out_valid, 1);
      tick();
      check("t2_valid_one_cycle", a_out_valid, 0);
      check("t2_halted", a_halted, 1);
      check("t2_pc", a_pc, 4);
      check("t2_retired", a_retired, 5);

      // Test 3: prog_we during RUN is ignored; the same write in HALT takes effect.
      load_a(4'd0, 8'h0F);  // LD R0,[15]
      load_a(4'd1, 8'h4F);  // ST R0,[15]
      load_a(4'd2, 8'h13);  // LD R1,[3]
      load_a(4'd3, 8'h5F);  // ST R1,[15]
      load_a(4'd4, 8'hF4);  // JZ R3,4
      run_a();
      a_in_port = 8'h5A;
      a_prog_we = 1'b1; a_prog_addr = 4'd1; a_prog_data = 8'h43;  // ST R0,[3]
      tick();
      a_prog_we = 1'b0;
      tick();
      check("t3_run_out", a_out_port, 8'h5A);
      check("t3_run_valid", a_out_valid, 1);
      tick(); tick();
      check("t3_dmem3_zero", a_out_port, 8'h00);
      check("t3_dmem3_valid", a_out_valid, 1);
      tick();
      check("t3_halted", a_halted, 1);
      load_a(4'd1, 8'h43);
      run_a();
      a_in_port = 8'h77; tick();
      tick();
      check("t3_new_word_no_valid", a_out_valid, 0);
      check("t3_new_word_port_held", a_out_port, 8'h00);
      tick(); tick();
      check("t3_dmem3_written", a_out_port, 8'h77);
      tick();
      check("t3_halted_again", a_halted, 1);

      // Test 4: reset mid-RUN after ST to address 3 clears dmem and outputs.
      load_a(4'd0, 8'h13);  // LD R1,[3]
      load_a(4'd1, 8'h5F);  // ST R1,[15]
      load_a(4'd2, 8'h0F);  // LD R0,[15]
      load_a(4'd3, 8'h43);  // ST R0,[3]
      load_a(4'd4, 8'hF4);  // JZ R3,4
      run_a();
      tick(); tick();
      check("t4_prev_dmem3", a_out_port, 8'h77);
      a_in_port = 8'h33; tick();
      tick();
      #2 a_reset = 1'b1;
      #1;
      check("t4_rst_busy", a_busy, 0);
      check("t4_rst_pc", a_pc, 0);
      check("t4_rst_retired", a_retired, 0);
      check("t4_rst_out_port", a_out_port, 0);
      check("t4_rst_halted", a_halted, 0);
      tick();
      a_reset = 1'b0;
      run_a();
      tick(); tick();
      check("t4_dmem3_cleared_valid", a_out_valid, 1);
      check("t4_dmem3_cleared", a_out_port, 8'h00);
      a_in_port = 8'h44; tick();
      tick(); tick();
      check("t4_rerun_halted", a_halted, 1);
      check("t4_rerun_retired", a_retired, 5);

      // Test 5: 12-bit ALU on instance B.
      load_b(5'd0,  8'h3F);  // LD R3,[15]  (1)
      load_b(5'd1,  8'hAD);  // SUB R2,R3
      load_b(5'd2,  8'h6F);  // ST R2,[15]
      load_b(5'd3,  8'h1F);  // LD R1,[15]  (0F0)
      load_b(5'd4,  8'hA7);  // XOR R2,R1
      load_b(5'd5,  8'h6F);  // ST R2,[15]
      load_b(5'd6,  8'h0F);  // LD R0,[15]  (3C6)
      load_b(5'd7,  8'hA2);  // AND R2,R0
      load_b(5'd8,  8'h6F);  // ST R2,[15]
      load_b(5'd9,  8'h7F);  // ST R3,[15]
      load_b(5'd10, 8'h95);  // SUB R1,R1
      load_b(5'd11, 8'hDB);  // JZ R1,11
      run_b();
      b_in_port = 12'h001; tick();
      tick(); tick();
      check("t5_sub_wrap", b_out_port, 12'hFFF);
      b_in_port = 12'h0F0; tick();
      tick(); tick();
      check("t5_xor", b_out_port, 12'hF0F);
      b_in_port = 12'h3C6; tick();
      tick(); tick();
      check("t5_and", b_out_port, 12'h306);
      tick();
      check("t5_r3_unchanged", b_out_port, 12'h001);
      tick(); tick();
      check("t5_halted", b_halted, 1);
      check("t5_pc", b_pc, 11);
      check("t5_retired", b_retired, 12);

      // Test 6: all-NOP program wraps pc 31 -> 0 and the 4-bit counter saturates.
      for (int i = 0; i < 32; i++) load_b(5'(i), 8'h30);  // LD R3,[0]
      run_b();
      repeat (10) tick();
      check("t6_retired_10", b_retired, 10);
      check("t6_pc_10", b_pc, 10);
      repeat (21) tick();
      check("t6_pc_31", b_pc, 31);
      check("t6_retired_sat", b_retired, 15);
      tick();
      check("t6_pc_wrap", b_pc, 0);
      tick();
      check("t6_pc_33", b_pc, 1);
      check("t6_retired_33", b_retired, 15);
      check("t6_busy", b_busy, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
